demux4_router: RTL

DEMUX4_ROUTER -- requirements
Module: demux4_router

---
 rtl/demux4_router.sv | 96 +++++++++
 1 files changed

// File: rtl/demux4_router.sv
// demux4_router: routes one upstream word per cycle to one of four
// destinations, each with a single-entry holding register and a
// ready/valid handshake. Also counts accepted words since reset.
`timescale 1ns/1ps
module demux4_router #(
    parameter int WIDTH_DATA_LENGTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   sel_port,
    input  logic [WIDTH_DATA_LENGTH-1:0] port_in,
    output logic [WIDTH_DATA_LENGTH-1:0] port_out_0,
    output logic [WIDTH_DATA_LENGTH-1:0] port_out_1,
    output logic [WIDTH_DATA_LENGTH-1:0] port_out_2,
    output logic [WIDTH_DATA_LENGTH-1:0] port_out_3,
    output logic                         out_valid_0,
    output logic                         out_valid_1,
    output logic                         out_valid_2,
    output logic                         out_valid_3,
    input  logic                         out_ready_0,
    input  logic                         out_ready_1,
    input  logic                         out_ready_2,
    input  logic                         out_ready_3,
    output logic [15:0]                  xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [3:0]                   out_ready_vec;
    logic [3:0]                   out_valid_vec;
    logic [WIDTH_DATA_LENGTH-1:0] data_vec [4];
    logic                         in_xfer;
    logic [15:0]                  xfer_count_reg;

    assign out_ready_vec = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

    // A FULL destination that is draining this cycle can take a new word on
    // the same edge; in_valid is deliberately not part of this term.
    assign in_ready = ~out_valid_vec[sel_port] | out_ready_vec[sel_port];
    assign in_xfer  = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_dest
            localparam logic [1:0] PORT_IDX = 2'(gi);

            state_t                       state_reg;
            logic [WIDTH_DATA_LENGTH-1:0] data_reg;
            logic                         load;

            assign load = in_xfer & (sel_port == PORT_IDX);

            // Per-destination holding register: load on input transfer,
            // release on output transfer, otherwise hold the word stable.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else if (load) begin
                    state_reg <= FULL;
                    data_reg  <= port_in;
                end else if (state_reg == FULL && out_ready_vec[gi]) begin
                    state_reg <= EMPTY;
                end
            end

            assign out_valid_vec[gi] = (state_reg == FULL);
            assign data_vec[gi]      = data_reg;
        end
    endgenerate

    // Accepted-word counter; wraps silently at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_reg <= '0;
        end else if (in_xfer) begin
            xfer_count_reg <= xfer_count_reg + 16'd1;
        end
    end

    assign xfer_count  = xfer_count_reg;
    assign out_valid_0 = out_valid_vec[0];
    assign out_valid_1 = out_valid_vec[1];
    assign out_valid_2 = out_valid_vec[2];
    assign out_valid_3 = out_valid_vec[3];
    assign port_out_0  = data_vec[0];
    assign port_out_1  = data_vec[1];
    assign port_out_2  = data_vec[2];
    assign port_out_3  = data_vec[3];

endmodule
